// File: rtl/jtcps1_obj_pkg.sv
// Shared definitions for the CPS1 object line controller and draw engine benches.
package jtcps1_obj_pkg;

  // Cleared pixel value; low nibble 4'hF marks the pixel as transparent
  localparam logic [8:0] OBJ_CLR_VAL = 9'h1FF;
  // Last visible hdump position; pixels beyond it are never read or written
  localparam logic [8:0] OBJ_HLAST   = 9'd447;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DROP  = 2'd3
  } obj_state_e;

  // A pixel with colour 4'hF is transparent and must never overwrite the buffer
  function automatic logic is_opaque(input logic [8:0] data);
    return data[3:0] != 4'hF;
  endfunction

endpackage

// File: rtl/jtcps1_obj_linebuf.sv
// Ping-pong object line buffer: 1024x9 dual-port RAM addressed as {half, addr}.
// Port A takes engine writes, port B does the read/clear of the front half.
module jtcps1_obj_linebuf (
  input  logic       clk,
  input  logic [9:0] addr_a,
  input  logic [8:0] data_a,
  input  logic       we_a,
  input  logic [9:0] addr_b,
  input  logic [8:0] data_b,
  input  logic       we_b,
  output logic [8:0] q_b
);

  logic [8:0] mem [0:1023];

  // Both ports share one process so the array has a single driver; the
  // controller guarantees the two ports always address different halves.
  // NOTE: the RAM has no reset -- a reset loop over 1024 words would not map
  // onto block RAM, and the first line after reset is allowed to be garbage.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/jtcps1_obj_line_ctrl.sv
// Per-line sequencer for the CPS1 object draw engine: launches one draw per
// line, owns the ping-pong line buffer, reads and clears the front half for
// the mixer, and contains draws that overrun into the next line.
module jtcps1_obj_line_ctrl
  import jtcps1_obj_pkg::*;
#(
  parameter logic [8:0] CLR_VAL = OBJ_CLR_VAL,
  parameter logic [8:0] HLAST   = OBJ_HLAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       line_start,
  input  logic [7:0] vrender,
  input  logic [8:0] hdump,
  output logic       draw_start,
  output logic [7:0] draw_v,
  input  logic       draw_done,
  input  logic [8:0] buf_addr,
  input  logic [8:0] buf_data,
  input  logic       buf_wr,
  output logic [8:0] pxl,
  output logic       overrun,
  output logic       busy
);

  obj_state_e state;
  logic       bank;      // half being written; video reads ~bank
  logic       rd_vld;    // a read was issued last clk, clear it now
  logic [9:0] rd_addr;   // address of that read, in the half read at the time
  logic [8:0] rd_q;

  logic       wr_ok;
  logic       rd_ok;
  logic [9:0] addr_b;

  // Only a live draw may write; dropped draws, transparent pixels and
  // off-screen addresses are filtered out here.
  assign wr_ok = (state == ST_DRAW) && buf_wr && is_opaque(buf_data) &&
                 (buf_addr <= HLAST);
  assign rd_ok = pxl_cen && (hdump <= HLAST);

  // Port B reads on the pxl_cen clk and clears on the following clk. pxl_cen
  // is never asserted on consecutive clks, so the two uses never overlap.
  assign addr_b = rd_vld ? rd_addr : {~bank, hdump};

  jtcps1_obj_linebuf u_linebuf (
    .clk    (clk),
    .addr_a ({bank, buf_addr}),
    .data_a (buf_data),
    .we_a   (wr_ok),
    .addr_b (addr_b),
    .data_b (CLR_VAL),
    .we_b   (rd_vld),
    .q_b    (rd_q)
  );

  // Line sequencer: bank swap, draw line latch, draw launch and overrun handling
  // NOTE: every register here is assigned with <= so all branches see the
  // state from before this edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bank       <= 1'b0;
      draw_start <= 1'b0;
      draw_v     <= 8'd0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      draw_start <= 1'b0;
      if (line_start) begin
        bank   <= ~bank;
        draw_v <= vrender;
      end
      case (state)
        ST_IDLE: begin
          if (line_start) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          draw_start <= 1'b1;
          busy       <= 1'b1;
          state      <= ST_DRAW;
        end
        ST_DRAW: begin
          // A draw finishing on the very clk of the new line is not an overrun
          if (draw_done) begin
            if (line_start) begin
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (line_start) begin
            state   <= ST_DROP;
            overrun <= 1'b1;
          end
        end
        ST_DROP: begin
          // The late draw is issued for whatever draw_v holds by then
          if (draw_done) state <= ST_START;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Front-half readout: capture the read address, then present data and clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_addr <= 10'd0;
      pxl     <= CLR_VAL;
    end else begin
      rd_vld <= rd_ok;
      if (rd_ok) rd_addr <= {~bank, hdump};
      if (rd_vld) pxl <= rd_q;
    end
  end

endmodule
